// File: rtl/memw1r1_init.sv
// 1-write/1-read single-clock RAM: pipelined registered read with valid strobe,
// selectable read/write collision policy, sequential post-reset init, sticky range error.
module memw1r1_init #(
  parameter int                 NUMWORDS  = 3,
  parameter int                 NUMBITS   = 72,
  parameter int                 ADDRWIDTH = $clog2(NUMWORDS),
  parameter int                 RDLAT     = 1,
  parameter int                 COLLISION = 0,
  parameter logic [NUMBITS-1:0] INITVAL   = {NUMBITS{1'b0}}
) (
  input  logic                 clk_a,
  input  logic                 rst_a_n,
  input  logic [ADDRWIDTH-1:0] addr_a,
  input  logic [NUMBITS-1:0]   wen_a,
  input  logic [NUMBITS-1:0]   di_a,
  input  logic                 ren_b,
  input  logic [ADDRWIDTH-1:0] addr_b,
  output logic [NUMBITS-1:0]   do_b,
  output logic                 dv_b,
  output logic                 init_done,
  output logic                 err_addr
);

  localparam logic [ADDRWIDTH:0]   LIMIT     = (ADDRWIDTH+1)'(NUMWORDS);
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NUMWORDS - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   init_we;

  logic [NUMBITS-1:0]     mem_q [NUMWORDS];

  logic                   run;
  logic                   wr_req, wr_ok, wr_go;
  logic                   rd_ok, rd_go;
  logic [NUMBITS-1:0]     rd_old, rd_merged, rd_word;

  logic                   vld_p0;
  logic [NUMBITS-1:0]     data_p0;
  logic                   vld_last;
  logic [NUMBITS-1:0]     data_last;
  logic                   dv_q;
  logic [NUMBITS-1:0]     do_q;

  function automatic logic in_range(input logic [ADDRWIDTH-1:0] a);
    return ({1'b0, a} < LIMIT);
  endfunction

  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    init_we = 1'b0;
    if (state_q == ST_INIT) begin
      init_we = 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDRWIDTH'(1);
      end
    end
  end

  assign run    = (state_q == ST_RUN);
  assign wr_req = run && (|wen_a);
  assign wr_ok  = in_range(addr_a);
  assign wr_go  = wr_req && wr_ok;
  assign rd_go  = run && ren_b;
  assign rd_ok  = in_range(addr_b);

  // Range errors are only observed once the ports are live.
  assign err_d = err_q | (wr_req && !wr_ok) | (rd_go && !rd_ok);

  assign rd_old    = mem_q[addr_b];
  assign rd_merged = (rd_old & ~wen_a) | (di_a & wen_a);

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      if ((COLLISION != 0) && wr_go && (addr_a == addr_b)) begin
        rd_word = rd_merged;
      end else begin
        rd_word = rd_old;
      end
    end
  end

  always_ff @(posedge clk_a) begin
    if (init_we) begin
      mem_q[cnt_q] <= INITVAL;
    end else if (wr_go) begin
      mem_q[addr_a] <= (mem_q[addr_a] & ~wen_a) | (di_a & wen_a);
    end
  end

  // p0: word captured at the request edge
  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_go;
    end
  end

  always_ff @(posedge clk_a) begin
    if (rd_go) begin
      data_p0 <= rd_word;
    end
  end

  generate
    if (RDLAT >= 2) begin : g_lat2
      logic               vld_p1;
      logic [NUMBITS-1:0] data_p1;

      // p1: extra stage for two-clock latency
      always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
          vld_p1 <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
        end
      end

      always_ff @(posedge clk_a) begin
        if (vld_p0) begin
          data_p1 <= data_p0;
        end
      end

      assign vld_last  = vld_p1;
      assign data_last = data_p1;
    end else begin : g_lat1
      assign vld_last  = vld_p0;
      assign data_last = data_p0;
    end
  endgenerate

  // Output register: holds the last completed word between strobes.
  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      dv_q <= 1'b0;
      do_q <= '0;
    end else begin
      dv_q <= vld_last;
      if (vld_last) begin
        do_q <= data_last;
      end
    end
  end

  assign do_b      = do_q;
  assign dv_b      = dv_q;
  assign init_done = done_q;
  assign err_addr  = err_q;

endmodule

// File: tb/tb_memw1r1_init.sv
// Scoreboard bench for memw1r1_init: two instances (RDLAT=1/COLLISION=0 and
// RDLAT=2/COLLISION=1) share one stimulus stream; a monitor checks every strobe.
module tb_memw1r1_init;

  localparam int         NW = 5;
  localparam int         NB = 8;
  localparam int         AW = 3;
  localparam logic [7:0] IV = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_a_n;
  logic [AW-1:0] addr_a, addr_b;
  logic [NB-1:0] wen_a, di_a;
  logic          ren_b;

  logic [NB-1:0] do0, do1;
  logic          dv0, dv1, done0, done1, err0, err1;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  memw1r1_init #(.NUMWORDS(NW), .NUMBITS(NB), .RDLAT(1), .COLLISION(0), .INITVAL(IV)) u_l1c0 (
    .clk_a(clk), .rst_a_n(rst_a_n), .addr_a(addr_a), .wen_a(wen_a), .di_a(di_a),
    .ren_b(ren_b), .addr_b(addr_b), .do_b(do0), .dv_b(dv0), .init_done(done0), .err_addr(err0)
  );

  memw1r1_init #(.NUMWORDS(NW), .NUMBITS(NB), .RDLAT(2), .COLLISION(1), .INITVAL(IV)) u_l2c1 (
    .clk_a(clk), .rst_a_n(rst_a_n), .addr_a(addr_a), .wen_a(wen_a), .di_a(di_a),
    .ren_b(ren_b), .addr_b(addr_b), .do_b(do1), .dv_b(dv1), .init_done(done1), .err_addr(err1)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic drv(input logic [2:0] aa, input logic [7:0] we, input logic [7:0] d,
                     input logic rb, input logic [2:0] ab);
    addr_a = aa;
    wen_a  = we;
    di_a   = d;
    ren_b  = rb;
    addr_b = ab;
  endtask

  task automatic push(input logic [7:0] e0, input logic [7:0] e1);
    q0.push_back('{e0, edge_n + 2});
    q1.push_back('{e1, edge_n + 3});
  endtask

  task automatic idle();
    drv(3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] we, input logic [7:0] d);
    drv(a, we, d, 1'b0, 3'd0);
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e0, input logic [7:0] e1);
    push(e0, e1);
    drv(3'd0, 8'h00, 8'h00, 1'b1, a);
    @(negedge clk);
  endtask

  task automatic wrrd(input logic [2:0] wa, input logic [7:0] we, input logic [7:0] d,
                      input logic [2:0] ra, input logic [7:0] e0, input logic [7:0] e1);
    push(e0, e1);
    drv(wa, we, d, 1'b1, ra);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_do_l1c0"}, do0, 8'h00);
    chk({tag, "_dv_l1c0"}, 8'(dv0), 8'h00);
    chk({tag, "_done_l1c0"}, 8'(done0), 8'h00);
    chk({tag, "_err_l1c0"}, 8'(err0), 8'h00);
    chk({tag, "_do_l2c1"}, do1, 8'h00);
    chk({tag, "_dv_l2c1"}, 8'(dv1), 8'h00);
    chk({tag, "_done_l2c1"}, 8'(done1), 8'h00);
    chk({tag, "_err_l2c1"}, 8'(err1), 8'h00);
  endtask

  task automatic init_seq(input string tag);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk({tag, "_done_l1c0"}, 8'(done0), 8'(k == 5));
      chk({tag, "_done_l2c1"}, 8'(done1), 8'(k == 5));
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (dv0 !== 1'b0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL rd_l1c0 stray strobe data %h at edge %0d, want none", do0, edge_n);
      end else begin
        e = q0.pop_front();
        if (do0 !== e.data || edge_n != e.due) begin
          errors++;
          $display("FAIL rd_l1c0 got %h at edge %0d want %h at edge %0d", do0, edge_n, e.data, e.due);
        end
      end
    end
    if (dv1 !== 1'b0) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rd_l2c1 stray strobe data %h at edge %0d, want none", do1, edge_n);
      end else begin
        e = q1.pop_front();
        if (do1 !== e.data || edge_n != e.due) begin
          errors++;
          $display("FAIL rd_l2c1 got %h at edge %0d want %h at edge %0d", do1, edge_n, e.data, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a_n = 1'b0;
    drv(3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // Init with accesses attempted during INIT: write to word 0, read, out-of-range write.
    rst_a_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      case (k)
        3:       drv(3'd0, 8'hFF, 8'h3C, 1'b0, 3'd0);
        4:       drv(3'd0, 8'h00, 8'h00, 1'b1, 3'd1);
        5:       drv(3'd7, 8'hFF, 8'hFF, 1'b0, 3'd0);
        default: drv(3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
      endcase
      @(negedge clk);
      chk("init_done_l1c0", 8'(done0), 8'(k == 5));
      chk("init_done_l2c1", 8'(done1), 8'(k == 5));
    end
    chk("init_err_l1c0", 8'(err0), 8'h00);
    chk("init_err_l2c1", 8'(err1), 8'h00);

    for (int a = 0; a < NW; a++) rd(3'(a), 8'hA5, 8'hA5);

    wr(3'd2, 8'hFF, 8'h00);
    wr(3'd2, 8'h0F, 8'hFF);
    rd(3'd2, 8'h0F, 8'h0F);
    wr(3'd2, 8'hF0, 8'h3C);
    rd(3'd2, 8'h3F, 8'h3F);

    wr(3'd1, 8'hFF, 8'h11);
    wrrd(3'd1, 8'hFF, 8'h22, 3'd1, 8'h11, 8'h22);
    rd(3'd1, 8'h22, 8'h22);
    wr(3'd3, 8'hFF, 8'hF0);
    wrrd(3'd3, 8'h0F, 8'h05, 3'd3, 8'hF0, 8'hF5);
    rd(3'd3, 8'hF5, 8'hF5);
    wrrd(3'd4, 8'hFF, 8'h5A, 3'd0, 8'hA5, 8'hA5);
    rd(3'd4, 8'h5A, 8'h5A);
    idle();
    chk("run_err_l1c0", 8'(err0), 8'h00);
    chk("run_err_l2c1", 8'(err1), 8'h00);

    wr(3'd6, 8'hFF, 8'hFF);
    chk("oob_wr_err_l1c0", 8'(err0), 8'h01);
    chk("oob_wr_err_l2c1", 8'(err1), 8'h01);
    rd(3'd7, 8'h00, 8'h00);
    rd(3'd0, 8'hA5, 8'hA5);
    rd(3'd1, 8'h22, 8'h22);
    rd(3'd2, 8'h3F, 8'h3F);
    rd(3'd3, 8'hF5, 8'hF5);
    rd(3'd4, 8'h5A, 8'h5A);
    repeat (4) idle();
    chk("sticky_err_l1c0", 8'(err0), 8'h01);
    chk("sticky_err_l2c1", 8'(err1), 8'h01);
    chk("hold_do_l1c0", do0, 8'h5A);
    chk("hold_do_l2c1", do1, 8'h5A);

    // Reset with reads in flight: only the RDLAT=1 result of the first read completes.
    q0.push_back('{8'hA5, edge_n + 2});
    drv(3'd0, 8'h00, 8'h00, 1'b1, 3'd0);
    @(negedge clk);
    drv(3'd0, 8'h00, 8'h00, 1'b1, 3'd1);
    @(negedge clk);
    #2;
    rst_a_n = 1'b0;
    drv(3'd0, 8'h00, 8'h00, 1'b0, 3'd0);
    #1;
    chk_zero("rst_inflight");
    repeat (3) @(negedge clk);

    // Reset again during init at counter 3, then a full restart.
    rst_a_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midinit_done_l1c0", 8'(done0), 8'h00);
    rst_a_n = 1'b0;
    #1;
    chk_zero("rst_midinit");
    @(negedge clk);
    rst_a_n = 1'b1;
    init_seq("reinit");

    for (int a = 0; a < NW; a++) rd(3'(a), 8'hA5, 8'hA5);
    repeat (4) idle();

    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL drain_l1c0 pending %0d want 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL drain_l2c1 pending %0d want 0", q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memw1r1_init.md
# memw1r1_init

Parametrised 1-write/1-read single-clock RAM. It is the successor to the flat-reset combinational-read memory model. It adds:
- a synchronous, pipelined read port with a data-valid strobe;
- a configurable read/write collision policy;
- a sequential post-reset initialisation engine, replacing the parallel array clear;
- a sticky out-of-range address flag.

It is used for FIFO and buffer storage in PCI-side datapaths and has one behavioural model for simulation and synthesis.

## Interface
Parameters:
- NUMWORDS, 3: number of words, 2 to 4096.
- NUMBITS, 72: word width in bits.
- ADDRWIDTH, ceil(log2(NUMWORDS)): address width; derived, not overridden.
- RDLAT, 1: read latency in clocks; legal values are 1 or 2.
- COLLISION, 0: policy for a same-cycle same-address write and read. 0 = read returns the old word. 1 = read returns the newly written word.
- INITVAL, {NUMBITS{1'b0}}: value written to every word by the init engine.

Ports:
- clk_a  in  1  clock; all logic is rising-edge.
- rst_a_n  in  1  reset; asynchronous assert, active-low.
- addr_a  in  ADDRWIDTH  write address.
- wen_a  in  NUMBITS  per-bit write enable; the port writes when |wen_a.
- di_a  in  NUMBITS  write data; only bits with wen_a[j]=1 are written.
- ren_b  in  1  read request.
- addr_b  in  ADDRWIDTH  read address, sampled when ren_b=1.
- do_b  out  NUMBITS  read data, registered.
- dv_b  out  1  one-cycle strobe marking do_b valid.
- init_done  out  1  high once initialisation completes.
- err_addr  out  1  sticky flag set by any out-of-range access.

## Operation
State machine: two states, INIT and RUN.
- Asserting rst_a_n low forces INIT and sets the init counter to 0. This applies at any time, including mid-init.
- INIT:
  - Each clock writes INITVAL to ram[counter], then increments the counter.
  - After writing word NUMWORDS-1 the block moves to RUN.
  - wen_a and ren_b are ignored in INIT. No write occurs, no read is issued, and err_addr is not updated.
- RUN: normal port operation. The block stays in RUN until reset.

Write:
- Applies when |wen_a and addr_a < NUMWORDS.
- ram[addr_a][j] is replaced by di_a[j] wherever wen_a[j]=1; all other bits are kept.

Read:
- Applies when ren_b=1 and addr_b < NUMWORDS.
- The word is captured into the read pipeline.
- The result reaches do_b with dv_b=1 after RDLAT clocks.

Collision (ren_b, |wen_a, and addr_a==addr_b in the same cycle):
- COLLISION=0: the read returns the pre-write word.
- COLLISION=1: the read returns the merged word, i.e. the old word with the masked bits replaced by di_a.
- In both modes the RAM is updated.

Out of range (addr >= NUMWORDS):
- A write is dropped; no RAM bit changes.
- A read still produces a dv_b strobe, with do_b = 0.
- Either case sets err_addr=1. err_addr clears only on reset.

Output hold: do_b keeps its last value when no read completes. dv_b is low on every cycle without a completing read.

Reset values: do_b=0, dv_b=0, init_done=0, err_addr=0. The read pipeline is flushed. RAM contents are undefined until INIT finishes.

## Timing
- Init:
  - After reset deasserts, the first rising edge writes word 0.
  - Word NUMWORDS-1 is written on edge NUMWORDS.
  - init_done rises on that same edge and is visible from cycle NUMWORDS onward.
  - The first accepted write or read is on the edge after init_done is seen high.
- Read latency:
  - A request sampled at edge N gives do_b/dv_b valid after edge N+RDLAT.
  - Back-to-back requests give one result per clock, with no bubbles.
- Write-to-read:
  - A write at edge N is visible to a non-colliding read sampled at edge N+1 or later.
  - Same-edge behaviour follows the COLLISION parameter.
- Reset mid-operation: reset immediately clears dv_b and flushes pipeline stages, so in-flight reads never produce a dv_b strobe. Init then restarts from word 0.
- init_done never falls except on reset.

## Test plan
- Init: NUMWORDS=5, INITVAL=8'hA5, NUMBITS=8. Release reset, then read all words. Expected: init_done high 5 cycles after release; every read returns 8'hA5; no access is honoured during INIT; a write issued during INIT leaves the word at A5.
- Bit-mask write: word 2 = 8'h00. Write wen_a=8'h0F, di_a=8'hFF, then read word 2. Expected: 8'h0F. Then write wen_a=8'hF0, di_a=8'h3C and read. Expected: 8'h3F.
- Latency and throughput: RDLAT=1 and RDLAT=2. Issue reads of words 0..4 on consecutive cycles. Expected: dv_b high for 5 consecutive cycles, starting RDLAT cycles after the first request; data in address order.
- Collision: word 1 = 8'h11. Same cycle: write 8'h22 with full mask to word 1, and read word 1. Expected: 8'h11 with COLLISION=0, 8'h22 with COLLISION=1; a following read returns 8'h22 in both modes.
- Out of range: NUMWORDS=5. Write 8'hFF to address 6, then read address 7. Expected: no word changes; the read returns 8'h00 with dv_b=1; err_addr=1 and stays high until reset.
- Reset mid-op: assert reset during init at counter=3, and separately with a read in flight. Expected: all outputs 0 immediately; no stray dv_b strobe; init restarts and takes the full 5 cycles.
